// File: rtl/flash_op_sequencer_pkg.sv
// Shared flash macro codes, SPI opcodes and sequencer state encoding.
// Also imported by the top-level macro state machine.
package flash_op_sequencer_pkg;

  localparam logic [3:0] FlashERS4kB = 4'hA;
  localparam logic [3:0] FlashRdID   = 4'hB;
  localparam logic [3:0] FlashWrPg   = 4'hC;
  localparam logic [3:0] FlashRdPg   = 4'hD;
  localparam logic [3:0] FlashRdSR   = 4'hE;
  localparam logic [3:0] FlashRdFR   = 4'hF;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE4K = 8'h20;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_WREN   = 4'd1;
  localparam logic [3:0] ST_WREN_W = 4'd2;
  localparam logic [3:0] ST_OP     = 4'd3;
  localparam logic [3:0] ST_OP_W   = 4'd4;
  localparam logic [3:0] ST_GAP    = 4'd5;
  localparam logic [3:0] ST_POLL   = 4'd6;
  localparam logic [3:0] ST_POLL_W = 4'd7;
  localparam logic [3:0] ST_FIN    = 4'd8;

  function automatic logic needs_wren(input logic [3:0] code);
    return (code == FlashERS4kB) || (code == FlashWrPg);
  endfunction

endpackage

// File: rtl/flash_op_sequencer.sv
// Expands one flash macro command into WREN / main opcode / RDSR poll
// transactions on the SPI command engine and reports a single done pulse.
module flash_op_sequencer
  import flash_op_sequencer_pkg::*;
#(
  parameter int POLL_GAP    = 64,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int PAGE_BYTES  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  macro_states,
  input  logic        macro_states_valid,
  input  logic [31:0] addr_reg,
  output logic        flash_done,
  output logic        flash_err,
  output logic        busy,
  output logic [7:0]  sr_value,
  output logic [23:0] id_value,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic        cmd_has_addr,
  output logic [23:0] cmd_addr,
  output logic [8:0]  cmd_len,
  output logic        cmd_rd,
  input  logic        cmd_done,
  input  logic [7:0]  rd_byte,
  input  logic        rd_byte_valid
);

  localparam logic [31:0] GAP_LIM = 32'(POLL_GAP);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYC);
  localparam logic [8:0]  PP_LEN  = 9'(PAGE_BYTES);

  logic [3:0]  state;
  logic [3:0]  state_d;
  logic [3:0]  code_q;
  logic [23:0] addr_q;
  logic        pend;
  logic        err_q;
  logic [7:0]  sr_q;
  logic [23:0] id_q;
  logic [31:0] gap_cnt;
  logic [31:0] to_cnt;
  logic        accept;
  logic        gap_done;
  logic        to_hit;
  logic        sr_wip;
  logic        err_set;
  logic        unused_ok;

  // pend gives the accepted code one cycle to settle before dispatch
  assign accept    = macro_states_valid && (state == ST_IDLE) && !pend;
  assign gap_done  = (gap_cnt + 32'd1) >= GAP_LIM;
  assign to_hit    = (to_cnt + 32'd1) >= TO_LIM;
  assign sr_wip    = rd_byte_valid ? rd_byte[0] : sr_q[0];
  assign unused_ok = ^addr_reg[31:24];

  always_comb begin
    state_d = state;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          if (needs_wren(code_q)) begin
            state_d = ST_WREN;
          end else if (code_q == FlashRdID) begin
            state_d = ST_OP;
          end else if (code_q == FlashRdSR) begin
            state_d = ST_POLL;
          end else begin
            state_d = ST_FIN;
            err_set = 1'b1;
          end
        end
      end
      ST_WREN:   if (cmd_ready) state_d = ST_WREN_W;
      ST_WREN_W: if (cmd_done)  state_d = ST_OP;
      ST_OP:     if (cmd_ready) state_d = ST_OP_W;
      ST_OP_W: begin
        if (cmd_done) state_d = (code_q == FlashRdID) ? ST_FIN : ST_GAP;
      end
      ST_GAP: begin
        if (gap_done) begin
          if (to_hit) begin
            state_d = ST_FIN;
            err_set = 1'b1;
          end else begin
            state_d = ST_POLL;
          end
        end
      end
      ST_POLL: if (cmd_ready) state_d = ST_POLL_W;
      ST_POLL_W: begin
        // a plain status read never loops on WIP
        if (cmd_done) begin
          if ((code_q == FlashRdSR) || !sr_wip) begin
            state_d = ST_FIN;
          end else if (to_hit) begin
            state_d = ST_FIN;
            err_set = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      code_q  <= 4'h0;
      addr_q  <= 24'h0;
      pend    <= 1'b0;
      err_q   <= 1'b0;
      sr_q    <= 8'h00;
      id_q    <= 24'h0;
      gap_cnt <= 32'd0;
      to_cnt  <= 32'd0;
    end else begin
      state <= state_d;
      pend  <= accept;
      if (accept) begin
        code_q <= macro_states;
        addr_q <= addr_reg[23:0];
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 32'd1 : 32'd0;
      if (accept || ((state == ST_OP_W) && cmd_done)) begin
        to_cnt <= 32'd0;
      end else if ((state == ST_GAP) || (state == ST_POLL) || (state == ST_POLL_W)) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if ((state == ST_POLL_W) && rd_byte_valid) begin
        sr_q <= rd_byte;
      end
      if ((state == ST_OP_W) && (code_q == FlashRdID) && rd_byte_valid) begin
        id_q <= {id_q[15:0], rd_byte};
      end
    end
  end

  // command fields are a pure function of state so they hold while valid
  always_comb begin
    cmd_opcode   = 8'h00;
    cmd_has_addr = 1'b0;
    cmd_addr     = 24'h0;
    cmd_len      = 9'd0;
    cmd_rd       = 1'b0;
    case (state)
      ST_WREN: cmd_opcode = OP_WREN;
      ST_OP: begin
        if (code_q == FlashERS4kB) begin
          cmd_opcode   = OP_SE4K;
          cmd_has_addr = 1'b1;
          cmd_addr     = addr_q;
        end else if (code_q == FlashWrPg) begin
          cmd_opcode   = OP_PP;
          cmd_has_addr = 1'b1;
          cmd_addr     = addr_q;
          cmd_len      = PP_LEN;
        end else if (code_q == FlashRdID) begin
          cmd_opcode = OP_RDID;
          cmd_len    = 9'd3;
          cmd_rd     = 1'b1;
        end
      end
      ST_POLL: begin
        cmd_opcode = OP_RDSR;
        cmd_len    = 9'd1;
        cmd_rd     = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_valid  = (state == ST_WREN) || (state == ST_OP) || (state == ST_POLL);
  assign flash_done = (state == ST_FIN);
  assign flash_err  = err_q;
  assign busy       = pend || (state != ST_IDLE);
  assign sr_value   = sr_q;
  assign id_value   = id_q;

endmodule
